// File: rtl/i2c_poll_pkg.sv
// i2c_poll_pkg: shared definitions for the I2C poll sequencer.
//   state_t        - sequencer FSM encoding (also exported on the debug port)
//   txn_t          - transaction kinds: init write, pointer write, data read
//   BACKOFF_CYCLES - clk cycles to wait before re-issuing a failed transaction
//   RW_WRITE/READ  - rw encoding understood by the bus master
package i2c_poll_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_REQ,
        S_INIT_WAIT,
        S_PTR_REQ,
        S_PTR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_BACKOFF,
        S_DELAY
    } state_t;

    typedef enum logic [1:0] {
        TXN_INIT,
        TXN_PTR,
        TXN_RD
    } txn_t;

    localparam int   BACKOFF_CYCLES = 1024;
    localparam logic RW_WRITE       = 1'b0;
    localparam logic RW_READ        = 1'b1;

    // Request state that (re-)issues a given transaction kind.
    function automatic state_t req_state(input txn_t t);
        case (t)
            TXN_INIT: return S_INIT_REQ;
            TXN_PTR:  return S_PTR_REQ;
            default:  return S_RD_REQ;
        endcase
    endfunction

endpackage

// File: rtl/i2c_poll_sequencer_sync.sv
// sync_2ff: W-bit double-flop synchronizer, async active-high reset.
//   clk, rst - destination clock and reset
//   d        - asynchronous input bits
//   q        - synchronized output bits (2 clk latency)
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer: drives an I2C master's request port to run an optional
// init write, then loop pointer-write / read / latch / idle-delay, with
// retries, per-phase timeouts and fault reporting.
//   clk, rst                 - system clock, async active-high reset
//   enable                   - run while high; falling edge clears fault
//   cfg_addr, init_data, init_bytes, reg_ptr, read_bytes,
//   poll_interval, timeout, retry_limit - configuration (levels)
//   m_start/m_rw/m_stop/m_wakeup/m_addr/m_bytes/m_data_out - master request
//   m_busy, m_error, m_data_in - master status/data (bus-clock domain)
//   value, valid, sample_cnt, fault, err_cnt - host-side results
//   fsm_state                - current FSM state (debug)
//
// Handshake with the master: m_start is a level request held with stable
// fields until the synchronized busy is seen high; the transaction is over
// when synchronized busy falls, and m_error is sampled at that moment.
module i2c_poll_sequencer
    import i2c_poll_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int MAX_DIN  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [6:0]          cfg_addr,
    input  logic [MAX_BITS-1:0] init_data,
    input  logic [4:0]          init_bytes,
    input  logic [7:0]          reg_ptr,
    input  logic [4:0]          read_bytes,
    input  logic [31:0]         poll_interval,
    input  logic [31:0]         timeout,
    input  logic [3:0]          retry_limit,
    output logic                m_start,
    output logic                m_rw,
    output logic                m_stop,
    output logic                m_wakeup,
    output logic [6:0]          m_addr,
    output logic [4:0]          m_bytes,
    output logic [MAX_BITS-1:0] m_data_out,
    input  logic                m_busy,
    input  logic                m_error,
    input  logic [MAX_DIN-1:0]  m_data_in,
    output logic [MAX_DIN-1:0]  value,
    output logic                valid,
    output logic [15:0]         sample_cnt,
    output logic                fault,
    output logic [7:0]          err_cnt,
    output state_t              fsm_state
);

    localparam logic [4:0] MAX_RD_BYTES = 5'(MAX_DIN / 8);

    state_t             state, next_state;
    txn_t               txn;
    logic [31:0]        timer;
    logic [3:0]         retries;
    logic               restart;
    logic               enable_q;
    logic               busy_s, error_s;
    logic               timed_out, delay_done, backoff_done, exhausted;
    logic               attempt_ok, attempt_fail, load_req;
    logic [4:0]         rd_bytes;
    logic [MAX_DIN-1:0] rd_mask;

    // Busy resets to 1 so that after reset nothing is issued until the bus
    // has really been observed idle through the synchronizer.
    sync_2ff #(.W(2), .RST_VAL(2'b10)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({m_busy, m_error}),
        .q   ({busy_s, error_s})
    );

    assign m_stop    = 1'b1;
    assign m_wakeup  = 1'b0;
    assign fsm_state = state;
    assign m_start   = (state == S_INIT_REQ) || (state == S_PTR_REQ) || (state == S_RD_REQ);

    assign rd_bytes     = (read_bytes > MAX_RD_BYTES) ? MAX_RD_BYTES : read_bytes;
    assign timed_out    = (timeout != 32'd0) && (({1'b0, timer} + 33'd1) >= {1'b0, timeout});
    assign delay_done   = ({1'b0, timer} + 33'd1) >= {1'b0, poll_interval};
    assign backoff_done = (timer == 32'(BACKOFF_CYCLES - 1));
    assign exhausted    = (retries >= retry_limit);
    assign load_req     = (next_state != state) &&
                          ((next_state == S_INIT_REQ) || (next_state == S_PTR_REQ) || (next_state == S_RD_REQ));

    // Keep the low m_bytes*8 bits of the read data; m_bytes holds the
    // clamped read length for the whole read.
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < MAX_DIN; i++) begin
            rd_mask[i] = (i < 8 * int'(m_bytes));
        end
    end

    always_comb begin
        next_state   = state;
        attempt_ok   = 1'b0;
        attempt_fail = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !busy_s) begin
                    next_state = (init_bytes != 5'd0) ? S_INIT_REQ : S_PTR_REQ;
                end
            end
            S_INIT_REQ, S_PTR_REQ, S_RD_REQ: begin
                if (busy_s) begin
                    next_state = (state == S_INIT_REQ) ? S_INIT_WAIT :
                                 (state == S_PTR_REQ)  ? S_PTR_WAIT  : S_RD_WAIT;
                end else if (!enable) begin
                    next_state = S_IDLE;
                end else if (timed_out) begin
                    attempt_fail = 1'b1;
                end
            end
            S_INIT_WAIT, S_PTR_WAIT, S_RD_WAIT: begin
                if (!busy_s) begin
                    attempt_ok   = !error_s;
                    attempt_fail = error_s;
                end else if (timed_out) begin
                    attempt_fail = 1'b1;
                end
                if (attempt_ok) begin
                    if (!enable)                                      next_state = S_IDLE;
                    else if (state == S_INIT_WAIT)                    next_state = S_PTR_REQ;
                    else if (state == S_PTR_WAIT && read_bytes != 0)  next_state = S_RD_REQ;
                    else                                              next_state = S_DELAY;
                end
            end
            S_BACKOFF: begin
                if (!enable)           next_state = S_IDLE;
                else if (backoff_done) next_state = req_state(txn);
            end
            S_DELAY: begin
                if (!enable)         next_state = S_IDLE;
                else if (delay_done) next_state = (restart && init_bytes != 5'd0) ? S_INIT_REQ : S_PTR_REQ;
            end
            default: next_state = S_IDLE;
        endcase
        if (attempt_fail) begin
            if (!enable)         next_state = S_IDLE;
            else if (!exhausted) next_state = S_BACKOFF;
            else                 next_state = S_DELAY;
        end
    end

    // Request fields change only on entry to a request state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rw       <= 1'b0;
            m_addr     <= '0;
            m_bytes    <= '0;
            m_data_out <= '0;
            txn        <= TXN_INIT;
        end else if (load_req) begin
            m_addr <= cfg_addr;
            case (next_state)
                S_INIT_REQ: begin
                    txn        <= TXN_INIT;
                    m_rw       <= RW_WRITE;
                    m_bytes    <= init_bytes;
                    m_data_out <= init_data;
                end
                S_PTR_REQ: begin
                    txn        <= TXN_PTR;
                    m_rw       <= RW_WRITE;
                    m_bytes    <= 5'd1;
                    m_data_out <= {reg_ptr, {(MAX_BITS-8){1'b0}}};
                end
                default: begin
                    txn        <= TXN_RD;
                    m_rw       <= RW_READ;
                    m_bytes    <= rd_bytes;
                    m_data_out <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            retries    <= '0;
            restart    <= 1'b0;
            enable_q   <= 1'b0;
            value      <= '0;
            valid      <= 1'b0;
            sample_cnt <= '0;
            fault      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state    <= next_state;
            enable_q <= enable;
            valid    <= 1'b0;
            if (next_state != state) timer <= '0;
            else if (timer != '1)    timer <= timer + 32'd1;

            if (attempt_ok) begin
                retries <= '0;
                if (state == S_RD_WAIT) begin
                    value      <= m_data_in & rd_mask;
                    valid      <= 1'b1;
                    sample_cnt <= sample_cnt + 16'd1;
                end else if (state == S_PTR_WAIT && read_bytes == 5'd0) begin
                    valid <= 1'b1;
                end
            end

            if (attempt_fail) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (enable) begin
                    if (!exhausted) begin
                        retries <= retries + 4'd1;
                    end else begin
                        retries <= '0;
                        fault   <= 1'b1;
                        restart <= 1'b1;
                    end
                end
            end

            if (state == S_IDLE) begin
                retries <= '0;
                restart <= 1'b0;
            end
            if (state == S_DELAY && next_state != S_DELAY) restart <= 1'b0;
            if (enable_q && !enable) fault <= 1'b0;
        end
    end

endmodule

// File: doc/i2c_poll_sequencer.md
# i2c_poll_sequencer

Autonomous transaction sequencer that sits directly upstream of the I2C bus master and drives its start/addr/rw/bytes/data request port. After enable it runs an optional init write to a device, then loops: register-pointer write, data read, result latch, programmable idle interval. Retries and timeouts are built in. Results, a sample strobe and fault status go to the RIO host-register side.

## Interface
- MAX_BITS, 64, width of the master write-data port; write data is MSB-aligned.
- MAX_DIN, 64, width of the master read-data port; read data is LSB-aligned.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; run the sequence while high
- cfg_addr  in  7  device address
- init_data  in  MAX_BITS  init write payload, MSB-aligned
- init_bytes  in  5  init payload bytes; 0 skips init
- reg_ptr  in  8  register pointer written before each read
- read_bytes  in  5  bytes per read; 0 means pointer write only
- poll_interval  in  32  idle clk cycles between polls
- timeout  in  32  clk cycles allowed per handshake phase
- retry_limit  in  4  retries per transaction before fault
- m_start, m_rw, m_stop, m_wakeup  out  1 each  master request lines; m_stop is always 1, m_wakeup is always 0
- m_addr  out  7  to master set_addr
- m_bytes  out  5  to master set_bytes
- m_data_out  out  MAX_BITS  to master set_data_out
- m_busy, m_error  in  1 each  master status (from the slow bus-clock domain)
- m_data_in  in  MAX_DIN  master read data
- value  out  MAX_DIN  last good sample
- valid  out  1  one-clk pulse on each new sample
- sample_cnt  out  16  wrapping count of good samples
- fault  out  1  sticky; cleared on rst or on enable falling
- err_cnt  out  8  saturating count of failed attempts

## Operation
- m_busy and m_error pass through a 2-flop synchronizer. All decisions use the synchronized copies.
- States: IDLE, INIT_REQ, INIT_WAIT, PTR_REQ, PTR_WAIT, RD_REQ, RD_WAIT, BACKOFF, DELAY.
- IDLE: when enable=1 and synchronized busy=0, go to INIT_REQ; if init_bytes==0, go to PTR_REQ instead.
- *_REQ: drive the request fields and m_start=1.
  - Hold m_start until synchronized busy=1, then go to *_WAIT.
  - If the timer reaches timeout first, the attempt fails.
- Request fields per transaction:
  - Init: rw=0, bytes=init_bytes, data=init_data.
  - Pointer: rw=0, bytes=1, data={reg_ptr, 0}.
  - Read: rw=1, bytes=read_bytes clamped to MAX_DIN/8.
- *_WAIT: m_start=0.
  - When synchronized busy falls, sample m_error. If it is 0, the transaction succeeds; if it is 1, the attempt fails.
  - Exceeding timeout also fails the attempt.
- Success transitions:
  - INIT goes to PTR_REQ.
  - PTR goes to RD_REQ, or to DELAY when read_bytes==0 (valid still pulses and value is unchanged).
  - RD latches m_data_in masked to the low read_bytes*8 bits into value, pulses valid, increments sample_cnt, then goes to DELAY.
- Failed attempt: err_cnt++ (saturating at 255).
  - If retries < retry_limit: retries++, go to BACKOFF for 1024 clk, then re-issue the same transaction.
  - Otherwise: set fault, clear retries, go to DELAY, and restart from INIT (or PTR if init_bytes==0).
  - retries clears on every success.
- DELAY: count poll_interval clk cycles, then go to PTR_REQ; with poll_interval=0, go next clk.
- enable low:
  - In DELAY or BACKOFF: go to IDLE next clk.
  - In *_REQ before busy is seen: drop m_start and go to IDLE.
  - In *_WAIT: finish the transaction, latching the sample if it is a read, then go to IDLE.
- Re-enable always re-runs init.

## Timing
- Reset values: all outputs 0 except m_stop=1; value=0, sample_cnt=0, err_cnt=0, fault=0; state=IDLE.
- Request fields are stable for the whole time m_start=1 and change only in the clk where a *_REQ state is entered.
- Synchronizer adds 2 clk latency to busy and error edges.
- valid pulses exactly 1 clk after the clk in which busy-low is seen in RD_WAIT.
- The timeout counter restarts on every state entry. timeout=0 disables the timeout.
- Reset mid-transaction: outputs return to reset values immediately. After release, IDLE waits for synchronized busy=0 before issuing any request.
- sample_cnt wraps from 0xFFFF to 0.

## Structure
- Package i2c_poll_pkg holds:
  - the state encoding;
  - the transaction-kind constants INIT/PTR/RD;
  - BACKOFF_CYCLES=1024;
  - the RW_WRITE/RW_READ constants shared with the master.
- One sub-module: sync_2ff, a parameterised-width double-flop synchronizer with async active-high reset, used for {m_busy, m_error}.
- The master-side bus model for benches lives in the test directory, not in RTL.

## Test plan
- Init and read, happy path: init_bytes=2, init_data=0xA55A<<48, read_bytes=2, model returns 0x1234.
  - Expect requests in order: write(2), write(1, ptr), read(2).
  - Expect value=0x1234, valid one pulse, sample_cnt=1.
- NACK with retry: model sets m_error on the first pointer write, retry_limit=2.
  - Expect err_cnt=1, a 1024-clk backoff, the pointer write re-issued, then a good sample and fault=0.
- Retries exhausted: model errors every time, retry_limit=1.
  - Expect fault=1, err_cnt=2, sequence restarting from init after poll_interval.
- Start timeout: model never asserts busy, timeout=100.
  - Expect m_start to drop after 100 clk and err_cnt to increment.
- Masking and clamping:
  - read_bytes=1 with model data_in=0xFFFF_FFFF: expect value=0xFF.
  - read_bytes=20, MAX_DIN=64: expect m_bytes=8.
- Mid-operation control:
  - Reset asserted during RD_WAIT: expect all outputs at reset values, and no new m_start until model busy=0.
  - enable dropped in DELAY: expect IDLE next clk.
